// File: rtl/led_pattern_pkg.sv
// Mode encoding and shared constants for the multi-channel LED pattern generator.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } led_mode_t;

  localparam int MIN_PERIOD = 2;

  function automatic logic is_running(input led_mode_t m);
    return (m == MODE_BLINK) || (m == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: period counter, shadow config with pending flag, and the
// registered LED/wrap outputs. Shadowed configs are only applied at a wrap.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int CNT_W          = 24,
  parameter int DEFAULT_PERIOD = 12000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  led_mode_t        cfg_mode_i,
  input  logic [CNT_W-1:0] cfg_period_i,
  input  logic [CNT_W-1:0] cfg_duty_i,
  output logic             pending_o,
  output logic             led_o,
  output logic             wrap_o
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] RST_DUTY   = CNT_W'(DEFAULT_PERIOD / 2);
  localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);

  led_mode_t        mode_q, mode_d, sh_mode_q, sh_mode_d;
  logic [CNT_W-1:0] period_q, period_d, duty_q, duty_d, cnt_q, cnt_d;
  logic [CNT_W-1:0] sh_period_q, sh_period_d, sh_duty_q, sh_duty_d;
  logic             pending_q, pending_d, led_q, led_d, wrap_q, wrap_d;
  logic             running, at_end, take_now;
  logic [CNT_W-1:0] wr_period;

  assign wr_period = (cfg_period_i < MIN_P) ? MIN_P : cfg_period_i;

  always_comb begin
    mode_d      = mode_q;
    period_d    = period_q;
    duty_d      = duty_q;
    sh_mode_d   = sh_mode_q;
    sh_period_d = sh_period_q;
    sh_duty_d   = sh_duty_q;
    pending_d   = pending_q;
    running     = is_running(mode_q);
    at_end      = running && (cnt_q == period_q - CNT_W'(1));
    wrap_d      = at_end;
    cnt_d       = (running && !at_end) ? cnt_q + CNT_W'(1) : '0;

    case (mode_q)
      MODE_OFF: led_d = 1'b0;
      MODE_ON:  led_d = 1'b1;
      default:  led_d = (cnt_q < duty_q);
    endcase

    if (at_end) begin
      if (pending_q) begin
        mode_d    = sh_mode_q;
        period_d  = sh_period_q;
        duty_d    = sh_duty_q;
        pending_d = 1'b0;
      end else if (mode_q == MODE_ONESHOT) begin
        mode_d = MODE_OFF;
      end
    end

    // A one-shot ending on this edge has no later wrap to apply a shadow on.
    take_now = !running || (at_end && (mode_q == MODE_ONESHOT));
    if (wr_en_i) begin
      if (take_now) begin
        mode_d   = cfg_mode_i;
        period_d = wr_period;
        duty_d   = cfg_duty_i;
        cnt_d    = '0;
      end else begin
        sh_mode_d   = cfg_mode_i;
        sh_period_d = wr_period;
        sh_duty_d   = cfg_duty_i;
        pending_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_BLINK;
      period_q    <= RST_PERIOD;
      duty_q      <= RST_DUTY;
      cnt_q       <= '0;
      sh_mode_q   <= MODE_BLINK;
      sh_period_q <= RST_PERIOD;
      sh_duty_q   <= RST_DUTY;
      pending_q   <= 1'b0;
      led_q       <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      cnt_q       <= cnt_d;
      sh_mode_q   <= sh_mode_d;
      sh_period_q <= sh_period_d;
      sh_duty_q   <= sh_duty_d;
      pending_q   <= pending_d;
      led_q       <= led_d;
      wrap_q      <= wrap_d;
    end
  end

  assign pending_o = pending_q;
  assign led_o     = led_q;
  assign wrap_o    = wrap_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator top: config decode, ready mux, channel array.
// Define LED_ACTIVE_LOW_EN to drive the led port active-low (resets to all-ones).
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter  int NUM_CH         = 2,
  parameter  int CNT_W          = 24,
  parameter  int DEFAULT_PERIOD = 12000000,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_duty,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] wrap
);

  logic [NUM_CH-1:0] pending, led_raw, wr_en;

  // Out-of-range channels match no pending flag, so they read ready and are dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((cfg_ch == CH_W'(i)) && pending[i]) cfg_ready = 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign wr_en[gi] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(gi));

      led_channel #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_ch (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (wr_en[gi]),
        .cfg_mode_i   (led_mode_t'(cfg_mode)),
        .cfg_period_i (cfg_period),
        .cfg_duty_i   (cfg_duty),
        .pending_o    (pending[gi]),
        .led_o        (led_raw[gi]),
        .wrap_o       (wrap[gi])
      );
    end
  endgenerate

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~led_raw;
`else
  assign led = led_raw;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized and directed bench for led_pattern_gen against a position-in-period model.
module tb_led_pattern_gen;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int DP     = 10;
  localparam int CH_W   = 1;
  localparam int M_OFF = 0, M_ON = 1, M_BLINK = 2, M_ONE = 3;
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [NUM_CH-1:0] INV = '1;
`else
  localparam logic [NUM_CH-1:0] INV = '0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [1:0]        cfg_mode = '0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic [CNT_W-1:0]  cfg_duty = '0;
  logic [NUM_CH-1:0] led, wrap;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(DP)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .led(led), .wrap(wrap)
  );

  // Model: a running channel's position is (edges since its period started) mod period.
  typedef struct {
    int mode; int period; int duty; int start;
    bit pend; int s_mode; int s_period; int s_duty;
  } ch_t;
  ch_t m [NUM_CH];

  int                k = 0;
  int                n_checks = 0;
  int                n_pass = 0;
  bit                last_xfer = 1'b0;
  logic              last_ready;
  logic [NUM_CH-1:0] last_e_led, last_e_wrap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, k);
  endtask

  task automatic model_reset(input int at);
    for (int i = 0; i < NUM_CH; i++) begin
      m[i].mode = M_BLINK; m[i].period = DP; m[i].duty = DP / 2; m[i].start = at;
      m[i].pend = 1'b0; m[i].s_mode = M_BLINK; m[i].s_period = DP; m[i].s_duty = DP / 2;
    end
  endtask

  // Called right after a falling edge with inputs already set; checks one cycle.
  task automatic tick();
    logic [NUM_CH-1:0] e_led, e_wrap;
    bit e_ready, xfer, run, fin, was_one;
    int cur, pos, per;
    #1;
    e_ready = !m[cfg_ch].pend;
    chk("cfg_ready", 32'(cfg_ready), 32'(e_ready));
    last_ready = cfg_ready;
    xfer = cfg_valid && e_ready;
    k++;
    cur = k - 1;
    for (int i = 0; i < NUM_CH; i++) begin
      run     = (m[i].mode == M_BLINK) || (m[i].mode == M_ONE);
      pos     = run ? (cur - m[i].start) % m[i].period : 0;
      e_led[i]  = (m[i].mode == M_ON) || (run && (pos < m[i].duty));
      fin     = run && (pos == m[i].period - 1);
      e_wrap[i] = fin;
      was_one = (m[i].mode == M_ONE);
      if (fin && m[i].pend) begin
        m[i].mode = m[i].s_mode; m[i].period = m[i].s_period; m[i].duty = m[i].s_duty;
        m[i].start = k; m[i].pend = 1'b0;
      end else if (fin && was_one) begin
        m[i].mode = M_OFF;
      end
      if (xfer && (int'(cfg_ch) == i)) begin
        per = (int'(cfg_period) < 2) ? 2 : int'(cfg_period);
        if (!run || (fin && was_one)) begin
          m[i].mode = int'(cfg_mode); m[i].period = per; m[i].duty = int'(cfg_duty);
          m[i].start = k;
        end else begin
          m[i].s_mode = int'(cfg_mode); m[i].s_period = per; m[i].s_duty = int'(cfg_duty);
          m[i].pend = 1'b1;
        end
      end
    end
    if (rst) begin
      model_reset(k);
      e_led = '0;
      e_wrap = '0;
    end
    @(negedge clk);
    chk("led", 32'(led), 32'(e_led ^ INV));
    chk("wrap", 32'(wrap), 32'(e_wrap));
    last_e_led  = e_led;
    last_e_wrap = e_wrap;
    last_xfer   = xfer;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int ch, input int mode, input int per, input int duty, output int used);
    cfg_ch = CH_W'(ch); cfg_mode = 2'(mode); cfg_period = CNT_W'(per); cfg_duty = CNT_W'(duty);
    cfg_valid = 1'b1;
    used = 0;
    do begin
      tick();
      used++;
    end while (!last_xfer && used < 100);
    if (!last_xfer) begin
      n_checks++;
      $display("FAIL wr_timeout: ch %0d not accepted after %0d cycles", ch, used);
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish, got stuck at edge %0d", k);
    $fatal(1);
  end

  initial begin
    int used, lowcnt;
    logic [19:0] h_led, h_wrap, e_hl, e_hw;
    logic [11:0] h12;
    logic [9:0]  h10_led, h10_wrap;
    logic [5:0]  h6;

    repeat (2) @(negedge clk);
    model_reset(0);
    tick();
    rst = 1'b0;

    // Reset defaults: 5 high / 5 low, wrap every 10.
    h_led = '0; h_wrap = '0; e_hl = '0; e_hw = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      h_led  = {h_led[18:0], led[0] ^ INV[0]};
      h_wrap = {h_wrap[18:0], wrap[0]};
      e_hl   = {e_hl[18:0], last_e_led[0]};
      e_hw   = {e_hw[18:0], last_e_wrap[0]};
    end
    chk("rst_led_seq", 32'(h_led), 32'(20'b11111000001111100000));
    chk("rst_wrap_seq", 32'(h_wrap), 32'(20'b00000000010000000001));
    chk("model_led_seq", 32'(e_hl), 32'(20'b11111000001111100000));
    chk("model_wrap_seq", 32'(e_hw), 32'(20'b00000000010000000001));

    // Deferred update on ch1 mid-period.
    idle(3);
    wr(1, M_BLINK, 6, 2, used);
    chk("defer_accept_cycles", 32'(used), 32'd1);
    cfg_ch = 1'b1;
    lowcnt = 0; h12 = '0;
    for (int j = 0; j < 18; j++) begin
      tick();
      if (!last_ready) lowcnt++;
      if (j >= 6) h12 = {h12[10:0], led[1] ^ INV[1]};
    end
    chk("defer_ready_low", 32'(lowcnt), 32'd6);
    chk("defer_led1_seq", 32'(h12), 32'(12'b110000110000));

    // ON / OFF / ONESHOT / clamp on ch0.
    wr(0, M_OFF, 10, 5, used);
    wr(0, M_ON, 10, 5, used);
    tick();
    chk("on_led", 32'(led[0] ^ INV[0]), 32'd1);
    wr(0, M_OFF, 10, 5, used);
    chk("off_immediate", 32'(used), 32'd1);
    wr(0, M_ONE, 8, 3, used);
    chk("oneshot_immediate", 32'(used), 32'd1);
    h10_led = '0; h10_wrap = '0;
    for (int j = 0; j < 10; j++) begin
      tick();
      h10_led  = {h10_led[8:0], led[0] ^ INV[0]};
      h10_wrap = {h10_wrap[8:0], wrap[0]};
    end
    chk("oneshot_led_seq", 32'(h10_led), 32'(10'b1110000000));
    chk("oneshot_wrap_seq", 32'(h10_wrap), 32'(10'b0000000100));
    wr(0, M_ONE, 4, 4, used);
    chk("oneshot_rewrite", 32'(used), 32'd1);
    idle(6);
    wr(0, M_BLINK, 0, 1, used);
    chk("clamp_immediate", 32'(used), 32'd1);
    h6 = '0;
    for (int j = 0; j < 6; j++) begin
      tick();
      h6 = {h6[4:0], led[0] ^ INV[0]};
    end
    chk("clamp_led_seq", 32'(h6), 32'(6'b101010));

    // Duty edge cases on ch1.
    wr(1, M_BLINK, 7, 0, used);
    idle(20);
    wr(1, M_BLINK, 7, 7, used);
    idle(20);

    // Randomized traffic with occasional resets; held requests stay stable.
    for (int n = 0; n < 800; n++) begin
      if (!cfg_valid || last_xfer) begin
        cfg_valid  = ($urandom_range(0, 3) == 0);
        cfg_ch     = CH_W'($urandom_range(0, NUM_CH - 1));
        cfg_mode   = 2'($urandom_range(0, 3));
        cfg_period = CNT_W'($urandom_range(0, 12));
        cfg_duty   = CNT_W'($urandom_range(0, 13));
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    idle(2);

    // Reset while a channel has a pending config.
    wr(1, M_BLINK, 10, 5, used);
    idle(12);
    wr(1, M_ONE, 6, 2, used);
    cfg_ch = 1'b1;
    tick();
    chk("pending_before_rst", 32'(last_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_led", 32'(led ^ INV), 32'd0);
    #1;
    chk("rst_mid_ready", 32'(cfg_ready), 32'd1);
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
